// File: rtl/block_slot_manager.sv
// block_slot_manager: double-buffered candidate block store.
// A producer fills the shadow bank one block per cycle; a frame start while
// the shadow list is complete copies it to the active bank in one cycle, so
// the selector never sees candidates move mid-frame.
// Optional feature macro: BLOCK_SLOT_STATS_EN adds stale-frame and
// dropped-list saturating counters.
module block_slot_manager #(
    parameter int          NUM_SLOTS = 12,
    parameter logic [13:0] FAR_Z     = 14'h3FFF
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    frame_start_in,
    input  logic                    blk_valid_in,
    output logic                    blk_ready_out,
    input  logic [11:0]             blk_x_in,
    input  logic [11:0]             blk_y_in,
    input  logic [13:0]             blk_z_in,
    input  logic                    blk_color_in,
    input  logic [2:0]              blk_direction_in,
    input  logic [7:0]              blk_id_in,
    input  logic                    list_done_in,
    output logic [NUM_SLOTS*12-1:0] block_x_out,
    output logic [NUM_SLOTS*12-1:0] block_y_out,
    output logic [NUM_SLOTS*14-1:0] block_z_out,
    output logic [NUM_SLOTS-1:0]    block_color_out,
    output logic [NUM_SLOTS*3-1:0]  block_direction_out,
    output logic [NUM_SLOTS*8-1:0]  block_ID_out,
    output logic [NUM_SLOTS-1:0]    block_visible_out,
`ifdef BLOCK_SLOT_STATS_EN
    output logic [15:0]             stale_frames_out,
    output logic [7:0]              dropped_lists_out,
`endif
    output logic                    swap_out,
    output logic                    pending_out
);

    localparam int IDX_W = $clog2(NUM_SLOTS + 1);
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(NUM_SLOTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [13:0] z;
        logic        color;
        logic [2:0]  dir;
        logic [7:0]  id;
        logic        visible;
    } slot_t;

    localparam slot_t EMPTY_SLOT = '{x: 12'd0, y: 12'd0, z: FAR_Z, color: 1'b0,
                                     dir: 3'd0, id: 8'd0, visible: 1'b0};

    typedef enum logic {ST_LOAD, ST_WAIT} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] wr_idx;
    logic             accept;
    logic             commit;
    slot_t            shadow [NUM_SLOTS];
    slot_t            active [NUM_SLOTS];
    slot_t            incoming;

    assign blk_ready_out = (state == ST_LOAD) && (wr_idx < FULL_IDX);
    assign accept        = blk_valid_in && blk_ready_out;
    assign pending_out   = (state == ST_WAIT);
    assign incoming      = '{x: blk_x_in, y: blk_y_in, z: blk_z_in, color: blk_color_in,
                             dir: blk_direction_in, id: blk_id_in, visible: 1'b1};

    // Next-state logic: a full list or list_done closes the list; frame start commits it.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            ST_LOAD: if (list_done_in || (accept && wr_idx == LAST_IDX)) state_next = ST_WAIT;
            ST_WAIT: if (frame_start_in) begin
                state_next = ST_LOAD;
                commit     = 1'b1;
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // State register, write index and the post-commit swap pulse.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= ST_LOAD;
            wr_idx   <= '0;
            swap_out <= 1'b0;
        end else begin
            state    <= state_next;
            swap_out <= commit;
            if (commit)      wr_idx <= '0;
            else if (accept) wr_idx <= wr_idx + 1'b1;
        end
    end

    // Shadow bank: filled by accepted blocks, emptied as soon as it is committed.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_SLOTS; i++) shadow[i] <= EMPTY_SLOT;
        end else if (commit) begin
            for (int i = 0; i < NUM_SLOTS; i++) shadow[i] <= EMPTY_SLOT;
        end else if (accept) begin
            shadow[wr_idx] <= incoming;
        end
    end

    // Active bank: changes only on a commit, all slots at once.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_SLOTS; i++) active[i] <= EMPTY_SLOT;
        end else if (commit) begin
            for (int i = 0; i < NUM_SLOTS; i++) active[i] <= shadow[i];
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign block_x_out[g*12 +: 12]        = active[g].x;
        assign block_y_out[g*12 +: 12]        = active[g].y;
        assign block_z_out[g*14 +: 14]        = active[g].z;
        assign block_color_out[g]             = active[g].color;
        assign block_direction_out[g*3 +: 3]  = active[g].dir;
        assign block_ID_out[g*8 +: 8]         = active[g].id;
        assign block_visible_out[g]           = active[g].visible;
    end

`ifdef BLOCK_SLOT_STATS_EN
    // Saturating counts of frames shown stale and list_done pulses arriving while waiting.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stale_frames_out  <= '0;
            dropped_lists_out <= '0;
        end else begin
            if (frame_start_in && state == ST_LOAD && stale_frames_out != 16'hFFFF)
                stale_frames_out <= stale_frames_out + 16'd1;
            if (list_done_in && state == ST_WAIT && dropped_lists_out != 8'hFF)
                dropped_lists_out <= dropped_lists_out + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_block_slot_manager.sv
// Bench for block_slot_manager: list-level reference model compared every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_block_slot_manager;
    localparam int N = 12;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic [13:0] z;
        logic        c;
        logic [2:0]  d;
        logic [7:0]  id;
    } blk_t;

    logic clk = 1'b0, rst = 1'b1, fs = 1'b0, valid = 1'b0, done = 1'b0;
    logic [11:0] bx = '0, by = '0;
    logic [13:0] bz = '0;
    logic        bc = 1'b0;
    logic [2:0]  bd = '0;
    logic [7:0]  bid = '0;

    logic            ready, swap, pend;
    logic [N*12-1:0] ox, oy;
    logic [N*14-1:0] oz;
    logic [N-1:0]    oc, ov;
    logic [N*3-1:0]  od;
    logic [N*8-1:0]  oid;
`ifdef BLOCK_SLOT_STATS_EN
    logic [15:0] stale;
    logic [7:0]  dropped;
`endif

    int total = 0;
    int bad   = 0;
    int swap_cnt = 0;

    block_slot_manager #(.NUM_SLOTS(N), .FAR_Z(14'h3FFF)) dut (
        .clk_in(clk), .rst_in(rst), .frame_start_in(fs),
        .blk_valid_in(valid), .blk_ready_out(ready),
        .blk_x_in(bx), .blk_y_in(by), .blk_z_in(bz),
        .blk_color_in(bc), .blk_direction_in(bd), .blk_id_in(bid),
        .list_done_in(done),
        .block_x_out(ox), .block_y_out(oy), .block_z_out(oz),
        .block_color_out(oc), .block_direction_out(od), .block_ID_out(oid),
        .block_visible_out(ov),
`ifdef BLOCK_SLOT_STATS_EN
        .stale_frames_out(stale), .dropped_lists_out(dropped),
`endif
        .swap_out(swap), .pending_out(pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: a list of accepted blocks, a pending flag, and the shown set.
    blk_t mlist[$];
    blk_t mact[N];
    bit   mvis[N];
    bit   m_pending, m_swap;
    int   m_stale, m_drop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mlist.delete();
            m_pending = 0;
            m_swap    = 0;
            m_stale   = 0;
            m_drop    = 0;
            for (int i = 0; i < N; i++) begin
                mact[i] = '{12'd0, 12'd0, 14'h3FFF, 1'b0, 3'd0, 8'd0};
                mvis[i] = 0;
            end
        end else begin
            m_swap = 0;
            if (!m_pending) begin
                if (fs && m_stale < 65535) m_stale++;
                if (valid && mlist.size() < N) mlist.push_back('{bx, by, bz, bc, bd, bid});
                if (done || mlist.size() == N) m_pending = 1;
            end else begin
                if (done && m_drop < 255) m_drop++;
                if (fs) begin
                    for (int i = 0; i < N; i++) begin
                        if (i < mlist.size()) begin
                            mact[i] = mlist[i];
                            mvis[i] = 1;
                        end else begin
                            mact[i] = '{12'd0, 12'd0, 14'h3FFF, 1'b0, 3'd0, 8'd0};
                            mvis[i] = 0;
                        end
                    end
                    mlist.delete();
                    m_pending = 0;
                    m_swap    = 1;
                end
            end
        end
    end

    // Every cycle out of reset, all outputs are compared with the model.
    always @(negedge clk) begin
        if (!rst) begin
            logic [N*12-1:0] ex, ey;
            logic [N*14-1:0] ez;
            logic [N-1:0]    ec, ev;
            logic [N*3-1:0]  ed;
            logic [N*8-1:0]  eid;
            for (int i = 0; i < N; i++) begin
                ex[i*12 +: 12] = mact[i].x;
                ey[i*12 +: 12] = mact[i].y;
                ez[i*14 +: 14] = mact[i].z;
                ec[i]          = mact[i].c;
                ed[i*3 +: 3]   = mact[i].d;
                eid[i*8 +: 8]  = mact[i].id;
                ev[i]          = mvis[i];
            end
            check("x", 256'(ox), 256'(ex));
            check("y", 256'(oy), 256'(ey));
            check("z", 256'(oz), 256'(ez));
            check("color", 256'(oc), 256'(ec));
            check("dir", 256'(od), 256'(ed));
            check("id", 256'(oid), 256'(eid));
            check("visible", 256'(ov), 256'(ev));
            check("ready", 256'(ready), 256'(!m_pending && mlist.size() < N));
            check("pending", 256'(pend), 256'(m_pending));
            check("swap", 256'(swap), 256'(m_swap));
`ifdef BLOCK_SLOT_STATS_EN
            check("stale", 256'(stale), 256'(m_stale));
            check("dropped", 256'(dropped), 256'(m_drop));
`endif
            if (swap) swap_cnt++;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one block and holds it until accepted; list_done may ride with it.
    task automatic send(input logic [11:0] x, input logic with_done);
        int   t = 0;
        logic acc;
        valid = 1'b1; bx = x; by = x + 12'd1; bz = {2'b01, x};
        bc = x[0]; bd = x[2:0]; bid = x[7:0]; done = with_done;
        do begin
            acc = ready;
            step();
            done = 1'b0;
            t++;
        end while (!acc && t < 40);
        valid = 1'b0;
        if (!acc) check("accept_timeout", 256'(0), 256'(1));
    endtask

    task automatic pulse_done();
        done = 1'b1; step(); done = 1'b0;
    endtask

    task automatic pulse_fs();
        fs = 1'b1; step(); fs = 1'b0;
    endtask

    initial begin
        int sc;
        step(2);
        @(negedge clk);
        rst = 1'b0;
        step();
        // Reset state
        check("rst_ready", 256'(ready), 256'(1));
        check("rst_pending", 256'(pend), 256'(0));
        check("rst_visible", 256'(ov), 256'(0));
        check("rst_z", 256'(oz), 256'({N{14'h3FFF}}));

        // Three blocks, list_done, frame_start
        send(12'd10, 1'b0); send(12'd20, 1'b0); send(12'd30, 1'b0);
        pulse_done();
        check("t1_pending", 256'(pend), 256'(1));
        sc = swap_cnt;
        pulse_fs();
        check("t1_x012", 256'(ox[35:0]), 256'({12'd30, 12'd20, 12'd10}));
        check("t1_visible", 256'(ov), 256'(12'b0000_0000_0111));
        check("t1_z3", 256'(oz[3*14 +: 14]), 256'(14'h3FFF));
        check("t1_z11", 256'(oz[11*14 +: 14]), 256'(14'h3FFF));
        step(3);
        check("t1_swap_once", 256'(swap_cnt - sc), 256'(1));

        // Thirteen blocks with valid held: ready drops after the 12th accept
        for (int i = 1; i <= 12; i++) send(12'(100 + i), 1'b0);
        valid = 1'b1; bx = 12'd113; by = 12'd114; bz = 14'd113; bc = 1'b1; bd = 3'd1; bid = 8'd113;
        step();
        check("t2_ready_low", 256'(ready), 256'(0));
        check("t2_pending", 256'(pend), 256'(1));
        pulse_fs();
        check("t2_slot11", 256'(ox[11*12 +: 12]), 256'(12'd112));
        check("t2_slot0", 256'(ox[11:0]), 256'(12'd101));
        check("t2_all_vis", 256'(ov), 256'(12'hFFF));
        step();
        valid = 1'b0;
        pulse_done();
        pulse_fs();
        step();
        check("t2_b13_slot0", 256'(ox[11:0]), 256'(12'd113));
        check("t2_b13_vis", 256'(ov), 256'(12'b1));

        // Frame start with nothing pending: stale frame, nothing moves
        sc = swap_cnt;
        pulse_fs();
        step(2);
        check("t3_no_swap", 256'(swap_cnt - sc), 256'(0));
        check("t3_held", 256'(ox[11:0]), 256'(12'd113));

        // list_done and frame_start together: commit waits for the next frame start
        send(12'd50, 1'b0);
        done = 1'b1; fs = 1'b1; step(); done = 1'b0; fs = 1'b0;
        step(2);
        check("t4_pending", 256'(pend), 256'(1));
        check("t4_no_swap", 256'(swap_cnt - sc), 256'(0));
        pulse_done();
        pulse_fs();
        step();
        check("t4_swap", 256'(swap_cnt - sc), 256'(1));
        check("t4_slot0", 256'(ox[11:0]), 256'(12'd50));

        // Reset after five accepts: outputs clear before the next clock edge
        for (int i = 0; i < 5; i++) send(12'(60 + i), 1'b0);
        #3 rst = 1'b1;
        #1;
        check("t5_vis", 256'(ov), 256'(0));
        check("t5_x", 256'(ox), 256'(0));
        check("t5_z", 256'(oz), 256'({N{14'h3FFF}}));
        check("t5_ready", 256'(ready), 256'(1));
        check("t5_pending", 256'(pend), 256'(0));
        @(negedge clk);
        #1 rst = 1'b0;
        step();
        send(12'd70, 1'b0); send(12'd71, 1'b1);
        pulse_fs();
        check("t5_reload", 256'(ox[23:0]), 256'({12'd71, 12'd70}));
        check("t5_reload_vis", 256'(ov), 256'(12'b11));

        // Stalled producer with junk data while valid is low
        send(12'd200, 1'b0);
        bx = 12'hABC; step();
        send(12'd201, 1'b0);
        bx = 12'hDEF; step(2);
        send(12'd202, 1'b1);
        pulse_fs();
        check("t6_order", 256'(ox[35:0]), 256'({12'd202, 12'd201, 12'd200}));
        check("t6_vis", 256'(ov), 256'(12'b111));
        check("t6_id2", 256'(oid[23:16]), 256'(8'd202));

        // Empty list commits an all-empty bank
        pulse_done();
        pulse_fs();
        check("t7_empty_vis", 256'(ov), 256'(0));
        check("t7_empty_z", 256'(oz), 256'({N{14'h3FFF}}));
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
